// File: rtl/bch_syndrome_gen.sv
// Serial BCH syndrome generator over GF(2^13). It evaluates the received polynomial
// at alpha^1..alpha^2T by Horner's rule and hands the syndromes on through a valid/ready register.
module bch_syndrome_gen #(
  parameter int T = 8,
  parameter int N = 1128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              din,
  output logic              synd_valid,
  input  logic              synd_ready,
  output logic [2*T*13-1:0] synd,
  output logic              err_free
);

  localparam int M  = 13;
  localparam int NS = 2 * T;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [M-1:0]  POLY_LOW = 13'h001B;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACC  = 1'b1;

  function automatic logic [M-1:0] mulX(input logic [M-1:0] a);
    return {a[M-2:0], 1'b0} ^ (a[M-1] ? POLY_LOW : '0);
  endfunction

  // Column i of the multiply-by-alpha^j matrix is alpha^(i+j); evaluated only on constants.
  function automatic logic [M*M-1:0] colTable(input int j);
    logic [M-1:0]   p;
    logic [M*M-1:0] cols;
    p    = 13'h0001;
    cols = '0;
    for (int e = 0; e < j; e++) p = mulX(p);
    for (int i = 0; i < M; i++) begin
      cols[i*M +: M] = p;
      p = mulX(p);
    end
    return cols;
  endfunction

  function automatic logic [M-1:0] mulConst(input logic [M-1:0] a, input logic [M*M-1:0] cols);
    logic [M-1:0] p;
    p = '0;
    for (int i = 0; i < M; i++) p ^= cols[i*M +: M] & {M{a[i]}};
    return p;
  endfunction

  logic [NS-1:0][M-1:0] accQ, accD;
  logic [NS-1:0][M-1:0] finalVal;
  logic [NS-1:0][M-1:0] syndQ, syndD;
  logic [CW-1:0]        cntQ, cntD;
  logic [0:0]           stateQ, stateD;
  logic                 syndValidQ, syndValidD;
  logic                 errFreeQ, errFreeD;
  logic                 lastBit;
  logic                 accept;
  logic                 loadOut;

  for (genvar j = 1; j <= NS; j++) begin : gMul
    localparam logic [M*M-1:0] COLS = colTable(j);
    assign finalVal[j-1] = mulConst(accQ[j-1], COLS) ^ {{(M-1){1'b0}}, din};
  end

  assign lastBit  = (cntQ == LAST) & ((stateQ == S_ACC) | (N == 1));
  assign in_ready = ~(syndValidQ & lastBit);
  assign accept   = in_valid & in_ready;
  assign loadOut  = accept & ~flush & lastBit;

  // Accumulator and bit counter; flush wins over an accept in the same cycle.
  always_comb begin
    accD   = accQ;
    cntD   = cntQ;
    stateD = stateQ;
    if (flush) begin
      accD   = '0;
      cntD   = '0;
      stateD = S_IDLE;
    end else if (accept) begin
      if (lastBit) begin
        accD   = '0;
        cntD   = '0;
        stateD = S_IDLE;
      end else begin
        accD   = finalVal;
        cntD   = cntQ + CW'(1);
        stateD = S_ACC;
      end
    end
  end

  // Output register holds until consumed; a fresh last bit reloads it.
  always_comb begin
    syndD      = syndQ;
    errFreeD   = errFreeQ;
    syndValidD = syndValidQ;
    if (syndValidQ & synd_ready) syndValidD = 1'b0;
    if (loadOut) begin
      syndD      = finalVal;
      errFreeD   = ~|finalVal;
      syndValidD = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accQ       <= '0;
      cntQ       <= '0;
      stateQ     <= S_IDLE;
      syndQ      <= '0;
      errFreeQ   <= 1'b0;
      syndValidQ <= 1'b0;
    end else begin
      accQ       <= accD;
      cntQ       <= cntD;
      stateQ     <= stateD;
      syndQ      <= syndD;
      errFreeQ   <= errFreeD;
      syndValidQ <= syndValidD;
    end
  end

  assign synd       = syndQ;
  assign err_free   = errFreeQ;
  assign synd_valid = syndValidQ;

endmodule

// File: tb/tb_bch_syndrome_gen.sv
// Directed bench for bch_syndrome_gen: hand-computed syndrome vectors, a power-sum
// reference model, and sequences for backpressure, flush and mid-codeword reset.
module tb_bch_syndrome_gen;

  localparam int T   = 8;
  localparam int N   = 1128;
  localparam int NS  = 2 * T;
  localparam int M   = 13;
  localparam int ORD = 8191;

  typedef struct {
    int          pos1;
    int          pos2;
    logic [12:0] s1;
    logic [12:0] s2;
    logic [12:0] s13;
    bit          hasS13;
    bit          errFree;
    bit          gaps;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              din;
  logic              synd_valid;
  logic              synd_ready;
  logic [NS*M-1:0]   synd;
  logic              err_free;

  int                checks = 0;
  int                errors = 0;
  bit                stuck  = 0;
  logic              cw [N];
  logic [M-1:0]      expTab [ORD];
  vec_t              vecs [7];
  logic [NS*M-1:0]   expSynd;
  logic [NS*M-1:0]   holdSynd;

  always #5 clk = ~clk;

  bch_syndrome_gen #(.T(T), .N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .din        (din),
    .synd_valid (synd_valid),
    .synd_ready (synd_ready),
    .synd       (synd),
    .err_free   (err_free)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkSynd(input string name, input logic [NS*M-1:0] act, input logic [NS*M-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: S_j = sum over set bits r_k of alpha^(j*k), from an exp table
  function automatic logic [NS*M-1:0] modelSynd();
    logic [NS*M-1:0] s;
    s = '0;
    for (int k = 0; k < N; k++)
      if (cw[k])
        for (int j = 1; j <= NS; j++)
          s[(j-1)*M +: M] ^= expTab[(j * k) % ORD];
    return s;
  endfunction

  task automatic clearCw(input logic v);
    for (int k = 0; k < N; k++) cw[k] = v;
  endtask

  task automatic sendBit(input logic b);
    int  waited;
    bit  done;
    waited = 0;
    done   = 0;
    while (!done && !stuck) begin
      @(negedge clk);
      in_valid = 1'b1;
      din      = b;
      done     = in_ready;
      @(posedge clk);
      waited++;
      if (!done && waited > 100) begin
        stuck = 1;
        checks++;
        errors++;
        $display("[TB] FAIL accept timeout: in_ready stayed 0 for %0d cycles, expected 1", waited);
      end
    end
  endtask

  // Sends r_hi down to r_lo; optionally inserts random idle cycles with junk on din
  task automatic applyStimulus(input int hi, input int lo, input bit gaps, input bit release_valid);
    for (int k = hi; k >= lo; k--) begin
      if (gaps && $urandom_range(3, 0) == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        din      = 1'($urandom);
        @(posedge clk);
      end
      sendBit(cw[k]);
    end
    if (release_valid) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [M-1:0]    a;
    logic [NS*M-1:0] oneVec;
    int              p1;
    int              p2;

    a = 13'h0001;
    for (int e = 0; e < ORD; e++) begin
      expTab[e] = a;
      a = a[12] ? ({a[11:0], 1'b0} ^ 13'h001B) : {a[11:0], 1'b0};
    end
    oneVec = '0;
    for (int j = 0; j < NS; j++) oneVec[j*M +: M] = 13'h0001;

    vecs[0] = '{-1, -1, 13'h0000, 13'h0000, 13'h0000, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{ 0, -1, 13'h0001, 13'h0001, 13'h0001, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{ 1, -1, 13'h0002, 13'h0004, 13'h001B, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{12, -1, 13'h1000, 13'h185A, 13'h0000, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{13, -1, 13'h001B, 13'h0145, 13'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{ 0,  1, 13'h0003, 13'h0005, 13'h001A, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{ 0, 13, 13'h001A, 13'h0144, 13'h0000, 1'b0, 1'b0, 1'b1};

    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    din        = 1'b0;
    synd_ready = 1'b1;
    #12;
    checkOutput("reset synd_valid", 32'(synd_valid), 0);
    checkOutput("reset err_free", 32'(err_free), 0);
    checkOutput("reset in_ready", 32'(in_ready), 1);
    checkSynd("reset synd", synd, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      clearCw(1'b0);
      if (vecs[v].pos1 >= 0) cw[vecs[v].pos1] = 1'b1;
      if (vecs[v].pos2 >= 0) cw[vecs[v].pos2] = 1'b1;
      expSynd = modelSynd();
      applyStimulus(N - 1, 0, vecs[v].gaps, 1'b1);
      checkOutput($sformatf("vec%0d valid", v), 32'(synd_valid), 1);
      checkOutput($sformatf("vec%0d S1", v), 32'(synd[12:0]), 32'(vecs[v].s1));
      checkOutput($sformatf("vec%0d S2", v), 32'(synd[25:13]), 32'(vecs[v].s2));
      if (vecs[v].hasS13)
        checkOutput($sformatf("vec%0d S13", v), 32'(synd[12*M +: M]), 32'(vecs[v].s13));
      checkOutput($sformatf("vec%0d err_free", v), 32'(err_free), 32'(vecs[v].errFree));
      checkSynd($sformatf("vec%0d model", v), synd, expSynd);
      @(negedge clk);
      checkOutput($sformatf("vec%0d valid pulse", v), 32'(synd_valid), 0);
    end

    for (int r = 0; r < 3; r++) begin
      p1 = $urandom_range(N - 1, 0);
      p2 = (p1 + 1 + $urandom_range(N - 2, 0)) % N;
      clearCw(1'b0);
      cw[p1] = 1'b1;
      cw[p2] = 1'b1;
      expSynd = modelSynd();
      applyStimulus(N - 1, 0, 1'b1, 1'b1);
      checkSynd($sformatf("rand%0d model (r_%0d,r_%0d)", r, p1, p2), synd, expSynd);
      checkOutput($sformatf("rand%0d err_free", r), 32'(err_free), 0);
    end

    // Backpressure: two all-ones codewords while synd_ready is low
    @(negedge clk);
    synd_ready = 1'b0;
    clearCw(1'b1);
    expSynd = modelSynd();
    applyStimulus(N - 1, 0, 1'b0, 1'b1);
    checkOutput("bp cw1 valid", 32'(synd_valid), 1);
    checkSynd("bp cw1 synd", synd, expSynd);
    applyStimulus(N - 1, 1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      din      = 1'b1;
      checkOutput($sformatf("bp stall in_ready %0d", i), 32'(in_ready), 0);
      checkSynd($sformatf("bp hold synd %0d", i), synd, expSynd);
      @(posedge clk);
    end
    @(negedge clk);
    synd_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    synd_ready = 1'b0;
    checkOutput("bp drained valid", 32'(synd_valid), 0);
    checkOutput("bp drained in_ready", 32'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp cw2 valid", 32'(synd_valid), 1);
    checkSynd("bp cw2 synd", synd, expSynd);
    checkOutput("bp cw2 err_free", 32'(err_free), 0);
    synd_ready = 1'b1;

    // Flush at cnt=500 with a pending r_1 result held
    @(negedge clk);
    synd_ready = 1'b0;
    clearCw(1'b0);
    cw[1] = 1'b1;
    holdSynd = modelSynd();
    applyStimulus(N - 1, 0, 1'b0, 1'b1);
    clearCw(1'b1);
    applyStimulus(N - 1, N - 500, 1'b0, 1'b0);
    @(negedge clk);
    flush    = 1'b1;
    in_valid = 1'b1;
    din      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush pending valid", 32'(synd_valid), 1);
    checkSynd("flush pending synd", synd, holdSynd);
    synd_ready = 1'b1;
    clearCw(1'b0);
    cw[0] = 1'b1;
    applyStimulus(N - 1, 0, 1'b0, 1'b1);
    checkOutput("after flush valid", 32'(synd_valid), 1);
    checkSynd("after flush synd", synd, oneVec);
    checkOutput("after flush err_free", 32'(err_free), 0);

    // Asynchronous reset mid-codeword at cnt=700 with a pending result
    @(negedge clk);
    synd_ready = 1'b0;
    applyStimulus(N - 1, 0, 1'b0, 1'b1);
    clearCw(1'b1);
    applyStimulus(N - 1, N - 700, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset valid", 32'(synd_valid), 0);
    checkOutput("async reset err_free", 32'(err_free), 0);
    checkOutput("async reset in_ready", 32'(in_ready), 1);
    checkSynd("async reset synd", synd, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    synd_ready = 1'b1;
    clearCw(1'b0);
    cw[1] = 1'b1;
    expSynd = modelSynd();
    applyStimulus(N - 1, 0, 1'b0, 1'b1);
    checkOutput("post reset valid", 32'(synd_valid), 1);
    checkOutput("post reset S1", 32'(synd[12:0]), 32'h0002);
    checkOutput("post reset S2", 32'(synd[25:13]), 32'h0004);
    checkSynd("post reset model", synd, expSynd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
